// File: rtl/rv_multicycle_ctrl_if.sv
// Instruction and data memory handshake bundle for the multi-cycle control FSM.
// The controller is the master: it raises requests, memory returns acks.
interface rv_multicycle_ctrl_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req,
    input  imem_ack,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// RV32I multi-cycle control FSM: fetch, decode, execute, memory, writeback.
// Traps permanently on an illegal opcode or an unacknowledged memory request.
module rv_multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  rv_multicycle_ctrl_if.master       bus,
  output logic [31:0]                instr_out,
  output logic [6:0]                 imm_sel,
  input  logic                       branch_taken,
  output logic                       alu_src_imm,
  output logic                       rf_we,
  output logic [1:0]                 wb_sel,
  output logic                       pc_we,
  output logic [1:0]                 pc_sel,
  output logic                       trap
);

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP       = 32'h00000013;
  localparam logic [15:0] TO_LIM    = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK,
    TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        br_q, br_d;
  logic [15:0] cnt_q, cnt_d;

  logic [6:0]  op;
  logic        is_load, is_store, is_branch, is_jal, is_lui, is_imm, op_legal;
  logic        imem_req_c, dmem_req_c, dmem_we_c;

  assign op        = instr_q[6:0];
  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign is_branch = (op == OP_BRANCH);
  assign is_jal    = (op == OP_JAL);
  assign is_lui    = (op == OP_LUI);
  assign is_imm    = (op == OP_IMM);
  assign op_legal  = (op == OP_R) || is_imm || is_load || is_store ||
                     is_branch || is_lui || is_jal;

  assign instr_out    = instr_q;
  assign imm_sel      = instr_q[6:0];
  assign bus.imem_req = imem_req_c;
  assign bus.dmem_req = dmem_req_c;
  assign bus.dmem_we  = dmem_we_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      instr_q <= NOP;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    br_d        = br_q;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    alu_src_imm = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 2'd0;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    trap        = 1'b0;

    unique case (state_q)
      FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = DECODE;
        end else if (cnt_q == TO_LIM) begin
          state_d = TRAP;
        end
      end
      DECODE: begin
        state_d = op_legal ? EXECUTE : TRAP;
      end
      EXECUTE: begin
        alu_src_imm = is_imm || is_load || is_store;
        if (is_branch) begin
          br_d = branch_taken;
        end
        state_d = (is_load || is_store) ? MEM : WRITEBACK;
      end
      MEM: begin
        dmem_req_c  = 1'b1;
        dmem_we_c   = is_store;
        alu_src_imm = 1'b1;
        if (bus.dmem_ack) begin
          state_d = WRITEBACK;
        end else if (cnt_q == TO_LIM) begin
          state_d = TRAP;
        end
      end
      WRITEBACK: begin
        pc_we = 1'b1;
        rf_we = !(is_store || is_branch);
        if (is_load) begin
          wb_sel = 2'd1;
        end else if (is_jal) begin
          wb_sel = 2'd2;
        end else if (is_lui) begin
          wb_sel = 2'd3;
        end
        if (is_jal) begin
          pc_sel = 2'd1;
        end else if (is_branch) begin
          pc_sel = {1'b0, br_q};
        end
        state_d = FETCH;
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = TRAP;
      end
    endcase

    // Counter only runs while a request stays in the same state; any transition
    // (ack, trap) restarts it, so it never exceeds the limit.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (imem_req_c || dmem_req_c) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = '0;
    end

    // Reset forces state to FETCH asynchronously; the request must not be seen
    // while rst_n is still low.
    if (!rst_n) begin
      imem_req_c = 1'b0;
      dmem_req_c = 1'b0;
      dmem_we_c  = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized bench for rv_multicycle_ctrl: per-instruction cycle counts and
// writeback controls are predicted from the opcode table and the ack delays.
module tb_rv_multicycle_ctrl;

  localparam int unsigned TO = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr_out;
  logic [6:0]  imm_sel;
  logic        branch_taken;
  logic        alu_src_imm;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        trap;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  rv_multicycle_ctrl_if bus ();

  rv_multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .instr_out    (instr_out),
    .imm_sel      (imm_sel),
    .branch_taken (branch_taken),
    .alu_src_imm  (alu_src_imm),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .trap         (trap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic legal_op(input logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL};
  endfunction

  task automatic do_reset;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_instr_out", instr_out, 32'h00000013);
    chk("rst_strobes", {bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we, pc_we, trap, alu_src_imm}, '0);
    chk("rst_sel", {wb_sel, pc_sel}, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one legal instruction from its first FETCH cycle to the next FETCH.
  task automatic run_instr(input logic [31:0] ins, input int unsigned fw,
                           input int unsigned mw, input logic bt);
    logic       e_rf, e_imm, e_mem, e_st;
    logic [1:0] e_wb, e_pc;
    int unsigned c, fc, mc, n_i, n_d, n_w, n_a, n_p, n_r, n_t;
    logic [1:0] wbs, pcs;
    logic       rfw, seen, done, ia, da;
    e_rf = 0; e_imm = 0; e_mem = 0; e_st = 0; e_wb = 0; e_pc = 0;
    case (ins[6:0])
      OP_R:      e_rf = 1;
      OP_IMM:    begin e_rf = 1; e_imm = 1; end
      OP_LOAD:   begin e_rf = 1; e_imm = 1; e_mem = 1; e_wb = 2'd1; end
      OP_STORE:  begin e_imm = 1; e_mem = 1; e_st = 1; end
      OP_BRANCH: e_pc = {1'b0, bt};
      OP_LUI:    begin e_rf = 1; e_wb = 2'd3; end
      OP_JAL:    begin e_rf = 1; e_wb = 2'd2; e_pc = 2'd1; end
      default:   ;
    endcase
    c = 0; fc = 0; mc = 0; n_i = 0; n_d = 0; n_w = 0; n_a = 0; n_p = 0; n_r = 0; n_t = 0;
    wbs = 0; pcs = 0; rfw = 0; seen = 0; done = 0;
    while (c < 40 && !done) begin
      if (seen && bus.imem_req) begin
        done = 1;
      end else begin
        n_i += 32'(bus.imem_req);
        n_d += 32'(bus.dmem_req);
        n_w += 32'(bus.dmem_we);
        n_a += 32'(alu_src_imm);
        n_p += 32'(pc_we);
        n_r += 32'(rf_we);
        n_t += 32'(trap);
        if (pc_we) begin
          seen = 1; rfw = rf_we; wbs = wb_sel; pcs = pc_sel;
        end
        if (bus.imem_req) begin ia = (fc == fw); fc++; end
        else ia = 1'($urandom_range(0, 1));
        if (bus.dmem_req) begin da = (mc == mw); mc++; end
        else da = 1'($urandom_range(0, 1));
        bus.imem_ack   = ia;
        bus.imem_rdata = (bus.imem_req && ia) ? ins : $urandom;
        bus.dmem_ack   = da;
        branch_taken   = (c == fw + 2) ? bt : 1'($urandom_range(0, 1));
        @(negedge clk);
        c++;
      end
    end
    chk("cpi", c, 4 + fw + (e_mem ? mw + 1 : 0));
    chk("imem_req_cycles", n_i, fw + 1);
    chk("dmem_req_cycles", n_d, e_mem ? mw + 1 : 0);
    chk("dmem_we_cycles", n_w, e_st ? mw + 1 : 0);
    chk("alu_src_imm_cycles", n_a, e_imm ? 1 + (e_mem ? mw + 1 : 0) : 0);
    chk("pc_we_pulses", n_p, 1);
    chk("rf_we_pulses", n_r, 32'(e_rf));
    chk("wb_rf_we", rfw, e_rf);
    if (e_rf) chk("wb_sel", wbs, e_wb);
    chk("pc_sel", pcs, e_pc);
    chk("no_trap", n_t, 0);
    chk("instr_out", instr_out, ins);
    chk("imm_sel", imm_sel, ins[6:0]);
  endtask

  task automatic run_illegal(input logic [31:0] ins, input int unsigned fw);
    int unsigned c, fc, n_p, n_r;
    logic got, ia;
    c = 0; fc = 0; n_p = 0; n_r = 0; got = 0;
    while (c < 20 && !got) begin
      if (trap) begin
        got = 1;
      end else begin
        n_p += 32'(pc_we);
        n_r += 32'(rf_we);
        if (bus.imem_req) begin ia = (fc == fw); fc++; end
        else ia = 1'($urandom_range(0, 1));
        bus.imem_ack   = ia;
        bus.imem_rdata = ins;
        bus.dmem_ack   = 1'($urandom_range(0, 1));
        @(negedge clk);
        c++;
      end
    end
    chk("ill_trap_cycle", c, fw + 2);
    chk("ill_pc_we", n_p, 0);
    chk("ill_rf_we", n_r, 0);
    for (int k = 0; k < 4; k++) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h00500093;
      bus.dmem_ack   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("trap_sticky", {trap, bus.imem_req, bus.dmem_req, pc_we, rf_we}, 5'b10000);
      chk("trap_instr_out", instr_out, ins);
    end
    do_reset;
    chk("post_rst_trap", trap, 0);
    chk("post_rst_imem_req", bus.imem_req, 1);
  endtask

  // Withholds either the fetch ack or the data-memory ack until the trap fires.
  task automatic run_stall(input logic [31:0] ins, input logic mem_stall);
    int unsigned c, n_i, n_d;
    logic got;
    c = 0; n_i = 0; n_d = 0; got = 0;
    while (c < 30 && !got) begin
      if (trap) begin
        got = 1;
      end else begin
        n_i += 32'(bus.imem_req);
        n_d += 32'(bus.dmem_req);
        bus.imem_ack   = mem_stall & bus.imem_req;
        bus.imem_rdata = ins;
        bus.dmem_ack   = 1'b0;
        branch_taken   = 1'b0;
        @(negedge clk);
        c++;
      end
    end
    chk("stall_trap", got, 1);
    chk("stall_imem_cycles", n_i, mem_stall ? 1 : TO + 1);
    chk("stall_dmem_cycles", n_d, mem_stall ? TO + 1 : 0);
    chk("stall_req_dropped", {bus.imem_req, bus.dmem_req, bus.dmem_we}, '0);
    do_reset;
  endtask

  task automatic reset_midreq(input logic in_mem);
    bus.imem_ack   = in_mem;
    bus.imem_rdata = 32'h00112023;
    bus.dmem_ack   = 1'b0;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_req_before", in_mem ? bus.dmem_req : bus.imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_req_drop", {bus.imem_req, bus.dmem_req, bus.dmem_we, alu_src_imm}, '0);
    do_reset;
  endtask

  initial begin
    logic [6:0]  ops [7];
    logic [31:0] r;
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL};
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ack = 1'b0;
    branch_taken = 1'b0;
    #1 do_reset;

    run_instr(32'h00500093, 0, 0, 1'b0);
    run_instr(32'h0000A103, 0, 3, 1'b0);
    run_instr(32'h00112023, 0, 2, 1'b0);
    run_instr(32'h00208463, 0, 0, 1'b1);
    run_instr(32'h00208463, 1, 0, 1'b0);
    run_instr(32'h00500093, TO, 0, 1'b0);
    run_instr(32'h0000A103, 0, TO, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      run_instr({r[31:7], ops[$urandom_range(0, 6)]}, $urandom_range(0, TO),
                $urandom_range(0, TO), 1'($urandom_range(0, 1)));
    end

    run_illegal(32'h0000007F, 0);
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      while (legal_op(r[6:0])) r = $urandom;
      run_illegal(r, $urandom_range(0, 3));
    end

    run_stall(32'h00500093, 1'b0);
    run_stall(32'h00112023, 1'b1);
    reset_midreq(1'b0);
    reset_midreq(1'b1);
    run_instr(32'h00500093, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
